iir_out_fifo: RTL and testbench

IIR_OUT_FIFO -- requirements
Module: iir_out_fifo

---
 rtl/iir_out_fifo.sv | 96 +++++++++
 tb/tb_iir_out_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_fifo.sv
// iir_out_fifo: first-word-fall-through output buffer for the iir_filter y
// stream. Each entry carries the signed sample plus a frame-last tag, which is
// set on every FRAME_LEN-th accepted sample. Samples arriving while full with
// no pop are dropped and latch the sticky overflow flag.
module iir_out_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int FRAME_LEN  = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [CW-1:0]         count
);

  // A frame of one sample still needs a 1-bit counter, which then stays at 0.
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   fcnt;
  logic            ovf;

  logic            push, pop, drop, fcnt_wrap;
  entry_t          head, wr_ent;

  // Status is derived from the registered occupancy only.
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign out_valid = !empty;
  assign count     = cnt;
  assign overflow  = ovf;

  // Handshake qualification: a pop frees the slot the push needs when full.
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign fcnt_wrap = (fcnt == FW'(FRAME_LEN - 1));

  assign wr_ent.last = fcnt_wrap;
  assign wr_ent.data = in_data;

  // Head presentation; zeros while empty so stale memory never leaks out.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rptr];
  end

  assign out_data = head.data;
  assign out_last = head.last;

  // Storage write; memory is not reset, stale entries are masked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_ent;
  end

  // Pointer, occupancy, frame counter and sticky overflow state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      fcnt <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
        fcnt <= fcnt_wrap ? '0 : fcnt + FW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed bench for iir_out_fifo: one task per scenario, inputs driven #1
// after the rising edge, outputs sampled in the same window.
module tb_iir_out_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  iir_out_fifo #(.DATA_WIDTH(16), .DEPTH(8), .FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .full(full), .empty(empty), .overflow(overflow),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 16'd77; out_ready = 1'b1;
    rst = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
        overflow !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b count=%0d empty=%b full=%b ovf=%b data=%h last=%b, want 0 0 1 0 0 0000 0",
               out_valid, count, empty, full, overflow, out_data, out_last);
    end
    rst = 1'b1;
  endtask

  task automatic test_buffering();
    logic [15:0] exp [3];
    exp[0] = 16'd6; exp[1] = -16'sd11; exp[2] = 16'd48;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = exp[i];
      tick();
      if (i == 0) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 16'd6) begin
          n_fail++;
          $display("FAIL buf_fwft: valid=%b data=%h, want 1 0006", out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== 4'd3) begin
      n_fail++;
      $display("FAIL buf_count: count=%0d, want 3", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL buf_pop%0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, exp[i]);
      end
      tick();
    end
    n_tests++;
    if (empty !== 1'b1 || out_data !== 16'd0) begin
      n_fail++;
      $display("FAIL buf_empty: empty=%b data=%h, want 1 0000", empty, out_data);
    end
  endtask

  task automatic test_framing();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      // previous head popped on the same edge, so sample i is now the head
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'(i) || out_last !== (i == 8 || i == 16) ||
          count !== 4'd1) begin
        n_fail++;
        $display("FAIL frame%0d: valid=%b data=%0d last=%b count=%0d, want 1 %0d %b 1",
                 i, out_valid, out_data, out_last, count, i, (i == 8 || i == 16));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      if (i == 8) begin
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b0 || count !== 4'd8) begin
          n_fail++;
          $display("FAIL ovf_full: full=%b ovf=%b count=%0d, want 1 0 8", full, overflow, count);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: ovf=%b count=%0d full=%b, want 1 8 1", overflow, count, full);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'(i) || out_last !== (i == 8) || overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: valid=%b data=%0d last=%b ovf=%b, want 1 %0d %b 1",
                 i, out_valid, out_data, out_last, overflow, i, (i == 8));
      end
      tick();
    end
    n_tests++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end: empty=%b ovf=%b, want 1 1", empty, overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp [8];
    logic        expl [8];
    for (int i = 0; i < 7; i++) begin exp[i] = 16'(i + 2); expl[i] = (i == 6); end
    exp[7] = 16'd100; expl[7] = 1'b0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    in_valid = 1'b1; in_data = 16'd100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (count !== 4'd8 || overflow !== 1'b0 || out_data !== 16'd2) begin
      n_fail++;
      $display("FAIL fullpop: count=%0d ovf=%b data=%0d, want 8 0 2", count, overflow, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== expl[i]) begin
        n_fail++;
        $display("FAIL fullpop_drain%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_data, out_last, exp[i], expl[i]);
      end
      tick();
    end
    n_tests++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_end: empty=%b ovf=%b, want 1 0", empty, overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
    end
    in_valid = 1'b1; in_data = 16'd99; out_ready = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (empty !== 1'b1 || count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: empty=%b count=%0d valid=%b, want 1 0 0", empty, count, out_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 20);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'(i + 20) || out_last !== (i == 8)) begin
        n_fail++;
        $display("FAIL midrst_drain%0d: valid=%b data=%0d last=%b, want 1 %0d %b",
                 i, out_valid, out_data, out_last, i + 20, (i == 8));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_buffering();
    test_framing();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
